// File: rtl/audio_adc_rx_pkg.sv
// -----------------------------------------------------------------------------
// audio_rx_pkg
// Shared definitions for the I2S ADC receiver: default parameter values,
// the capture FSM state encoding and the channel encoding (LRCK level).
// -----------------------------------------------------------------------------
package audio_rx_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_WAIT_MSB = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_SKIP     = 2'd3
  } rx_state_e;

  // LRCK low selects the left channel, high selects the right channel.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/audio_adc_rx_edge_sync.sv
// -----------------------------------------------------------------------------
// audio_edge_sync
// Multi-flop synchronizer for one asynchronous codec signal, plus one-cycle
// rise/fall strobes derived from the synchronized level.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_sig  : asynchronous input
//   o_sync : synchronized level (STAGES cycles of latency)
//   o_rise : one-cycle strobe on a 0->1 transition of o_sync
//   o_fall : one-cycle strobe on a 1->0 transition of o_sync
// -----------------------------------------------------------------------------
module audio_edge_sync
  import audio_rx_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Synchronizer chain and one-cycle-delayed copy of its output for edge detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain[0] <= i_sig;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/audio_adc_rx.sv
// -----------------------------------------------------------------------------
// audio_adc_rx
// I2S receiver for the codec ADC path. BCK, LRCK and DAT are brought into the
// iCLK domain through identical synchronizer chains so they stay aligned; the
// capture FSM samples DAT on each synchronized BCK rise, one bit after every
// LRCK transition, and pairs a completed left word with the following right
// word. A single output register with a valid/ready handshake holds the pair.
// Ports:
//   iCLK         : system clock (>= 4x BCK)
//   iRST         : synchronous active-high reset
//   iAUD_BCK     : codec bit clock
//   iAUD_ADCLRCK : word select, low = left, high = right
//   iAUD_ADCDAT  : serial data, MSB first
//   oLEFT/oRIGHT : captured sample pair
//   oVALID       : pair available; held until accepted with iREADY
//   iREADY       : consumer accepts the pair
//   oOVERFLOW    : sticky, a completed pair was dropped while the output was full
//   oFRAME_ERR   : sticky, a channel word was cut short by an LRCK edge
// -----------------------------------------------------------------------------
module audio_adc_rx
  import audio_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_ADCLRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] oLEFT,
  output logic [DATA_WIDTH-1:0] oRIGHT,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic                  oOVERFLOW,
  output logic                  oFRAME_ERR
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Synchronized codec signals and strobes
  logic w_bck_sync, w_bck_rise, w_bck_fall;
  logic w_lrck_sync, w_lrck_rise, w_lrck_fall, w_lrck_edge;
  logic w_dat_sync, w_dat_rise, w_dat_fall;
  logic w_unused_strobes;

  // FSM state and datapath
  rx_state_e             r_state, w_state_nxt;
  logic                  r_chan, w_chan_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  w_word_done;
  logic                  w_frame_err_set;

  // Left holding register and output stage
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic                  r_left_valid;
  logic [DATA_WIDTH-1:0] r_left_out, r_right_out;
  logic                  r_valid, r_overflow, r_frame_err;
  logic                  w_pair_done, w_xfer;

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_bck (
    .i_clk (iCLK), .i_rst (iRST), .i_sig (iAUD_BCK),
    .o_sync(w_bck_sync), .o_rise(w_bck_rise), .o_fall(w_bck_fall)
  );

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk (iCLK), .i_rst (iRST), .i_sig (iAUD_ADCLRCK),
    .o_sync(w_lrck_sync), .o_rise(w_lrck_rise), .o_fall(w_lrck_fall)
  );

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .i_clk (iCLK), .i_rst (iRST), .i_sig (iAUD_ADCDAT),
    .o_sync(w_dat_sync), .o_rise(w_dat_rise), .o_fall(w_dat_fall)
  );

  // Only the BCK rise, LRCK level/edges and DAT level drive the receiver.
  assign w_unused_strobes = ^{w_bck_sync, w_bck_fall, w_dat_rise, w_dat_fall};

  assign w_lrck_edge = w_lrck_rise | w_lrck_fall;

  // Capture FSM next-state logic. An LRCK edge always wins over a BCK rise.
  always_comb begin
    w_state_nxt     = r_state;
    w_chan_nxt      = r_chan;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_word_done     = 1'b0;
    w_frame_err_set = 1'b0;
    case (r_state)
      ST_SYNC: begin
        // Only a falling LRCK marks a frame start we can trust.
        if (w_lrck_fall) begin
          w_state_nxt = ST_WAIT_MSB;
          w_chan_nxt  = CH_LEFT;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_WAIT_MSB: begin
        // The first BCK rise after LRCK is the I2S one-bit delay slot.
        if (w_lrck_edge) begin
          w_state_nxt = ST_WAIT_MSB;
          w_chan_nxt  = w_lrck_sync;
        end else if (w_bck_rise) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_WAIT_MSB;
        end
      end
      ST_SHIFT: begin
        if (w_lrck_edge) begin
          // Word cut short: drop it and start the new channel.
          w_frame_err_set = 1'b1;
          w_state_nxt     = ST_WAIT_MSB;
          w_chan_nxt      = w_lrck_sync;
          w_cnt_nxt       = '0;
        end else if (w_bck_rise) begin
          w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_dat_sync};
          if (r_cnt == LAST_BIT) begin
            w_word_done = 1'b1;
            w_state_nxt = ST_SKIP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SKIP: begin
        // Trailing slot bits beyond DATA_WIDTH are ignored.
        if (w_lrck_edge) begin
          w_state_nxt = ST_WAIT_MSB;
          w_chan_nxt  = w_lrck_sync;
        end else begin
          w_state_nxt = ST_SKIP;
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
        w_chan_nxt  = CH_LEFT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Capture FSM state, channel, bit counter and shift register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_SYNC;
      r_chan  <= CH_LEFT;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign w_pair_done = w_word_done & (r_chan == CH_RIGHT) & r_left_valid;
  assign w_xfer      = r_valid & iREADY;

  // Left holding register and the sticky frame-error flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_left_hold  <= '0;
      r_left_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_frame_err_set) begin
        r_frame_err <= 1'b1;
      end
      if (w_word_done && (r_chan == CH_LEFT)) begin
        r_left_hold  <= w_shift_nxt;
        r_left_valid <= 1'b1;
      end else if (w_word_done && (r_chan == CH_RIGHT)) begin
        // A right word either consumes the pending left word or is orphaned;
        // either way nothing is pending afterwards.
        r_left_valid <= 1'b0;
      end
    end
  end

  // Output register: load on pair completion when empty or being drained,
  // otherwise drop the new pair and flag overflow.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_left_out  <= '0;
      r_right_out <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_pair_done) begin
      if (!r_valid || iREADY) begin
        r_left_out  <= r_left_hold;
        r_right_out <= w_shift_nxt;
        r_valid     <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign oLEFT      = r_left_out;
  assign oRIGHT     = r_right_out;
  assign oVALID     = r_valid;
  assign oOVERFLOW  = r_overflow;
  assign oFRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_audio_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_audio_adc_rx
// Directed bench for audio_adc_rx: an I2S codec model (BCK = iCLK/6) drives
// frames; expected pairs are queued as frames are sent and compared when the
// DUT hands a pair over (oVALID && iREADY).
// -----------------------------------------------------------------------------
module tb_audio_adc_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          bck;
  logic          lrck;
  logic          dat;
  logic          ready;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          valid;
  logic          ovf;
  logic          ferr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int base;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t         exp_q[$];
  logic          held = 1'b0;
  logic [DW-1:0] held_l;
  logic [DW-1:0] held_r;

  always #5 clk = ~clk;

  audio_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iAUD_BCK    (bck),
    .iAUD_ADCLRCK(lrck),
    .iAUD_ADCDAT (dat),
    .oLEFT       (left),
    .oRIGHT      (right),
    .oVALID      (valid),
    .iREADY      (ready),
    .oOVERFLOW   (ovf),
    .oFRAME_ERR  (ferr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare every handed-over pair, and check held outputs stay put.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_left",  32'(left),  32'(held_l));
        check("hold_right", 32'(right), 32'(held_r));
      end
      if (valid && ready) begin
        check("pair_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          pair_t p;
          p = exp_q.pop_front();
          check("xfer_left",  32'(left),  32'(p.l));
          check("xfer_right", 32'(right), 32'(p.r));
        end
        n_xfer++;
      end
      held   = valid && !ready;
      held_l = left;
      held_r = right;
    end
  end

  function automatic logic slot_bit(input logic [DW-1:0] w, input int s, input logic junk);
    if (s >= 1 && s <= DW) return w[DW-s];
    else return junk;
  endfunction

  // One BCK period: data/LRCK change with BCK low, BCK high for 3 clocks.
  task automatic bck_cycle(input logic lr, input logic d);
    lrck = lr;
    dat  = d;
    bck  = 1'b0;
    repeat (3) @(negedge clk);
    bck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // mode 0: plain; 1: latency check at right LSB; 2: iREADY rises at right LSB;
  // 3: reset pulse during right slot 5. left_bits < DW truncates the left word.
  task automatic send_frame(input logic [DW-1:0] lw, input logic [DW-1:0] rw,
                            input int slots, input logic junk, input int mode,
                            input int left_bits);
    int llen;
    llen = (left_bits < DW) ? left_bits + 1 : slots;
    for (int s = 0; s < llen; s++) bck_cycle(1'b0, slot_bit(lw, s, junk));
    for (int s = 0; s < slots; s++) begin
      if (mode == 1 && s == DW) begin
        lrck = 1'b1; dat = slot_bit(rw, s, junk); bck = 1'b0;
        repeat (3) @(negedge clk);
        bck = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("lat_not_early", 32'(valid), 32'd0);
        @(posedge clk); #1;
        check("lat_rise", 32'(valid), 32'd1);
        @(negedge clk);
      end else if (mode == 2 && s == DW) begin
        lrck = 1'b1; dat = slot_bit(rw, s, junk); bck = 1'b0;
        repeat (3) @(negedge clk);
        bck = 1'b1;
        repeat (2) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check("same_cyc_valid", 32'(valid), 32'd1);
        check("same_cyc_left",  32'(left),  32'(lw));
        check("same_cyc_right", 32'(right), 32'(rw));
        check("same_cyc_ovf",   32'(ovf),   32'd0);
      end else if (mode == 3 && s == 5) begin
        rst = 1'b1;
        bck_cycle(1'b1, slot_bit(rw, s, junk));
        rst = 1'b0;
      end else begin
        bck_cycle(1'b1, slot_bit(rw, s, junk));
      end
    end
  endtask

  initial begin
    rst = 1'b1; bck = 1'b0; lrck = 1'b1; dat = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_left",  32'(left),  32'd0);
    check("rst_right", 32'(right), 32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_ferr",  32'(ferr),  32'd0);

    // Basic frame, consumer always ready
    base = n_xfer;
    exp_q.push_back({16'h1234, 16'hABCD});
    send_frame(16'h1234, 16'hABCD, 18, 1'b0, 1, DW);
    repeat (4) @(negedge clk);
    check("basic_xfers", 32'(n_xfer - base), 32'd1);
    check("basic_valid_drop", 32'(valid), 32'd0);

    // Pair completes in the same cycle the previous pair is accepted
    ready = 1'b0;
    base = n_xfer;
    exp_q.push_back({16'h5A5A, 16'h0001});
    send_frame(16'h5A5A, 16'h0001, 18, 1'b0, 0, DW);
    check("pre_same_valid", 32'(valid), 32'd1);
    exp_q.push_back({16'h8000, 16'h7FFF});
    send_frame(16'h8000, 16'h7FFF, 18, 1'b0, 2, DW);
    repeat (4) @(negedge clk);
    check("same_cyc_xfers", 32'(n_xfer - base), 32'd2);
    check("same_cyc_ovf_end", 32'(ovf), 32'd0);

    // Consumer stalled over two frames: first pair held, second dropped
    ready = 1'b0;
    base = n_xfer;
    exp_q.push_back({16'hC3C3, 16'h3C3C});
    send_frame(16'hC3C3, 16'h3C3C, 18, 1'b0, 0, DW);
    send_frame(16'h1111, 16'h2222, 18, 1'b0, 0, DW);
    check("ovf_valid", 32'(valid), 32'd1);
    check("ovf_left",  32'(left),  32'hC3C3);
    check("ovf_right", 32'(right), 32'h3C3C);
    check("ovf_flag",  32'(ovf),   32'd1);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovf_xfers", 32'(n_xfer - base), 32'd1);
    check("ovf_valid_drop", 32'(valid), 32'd0);

    // Left word cut short after 10 bits, then a clean frame
    base = n_xfer;
    send_frame(16'hFFFF, 16'h0F0F, 18, 1'b0, 0, 10);
    check("ferr_flag", 32'(ferr), 32'd1);
    check("ferr_no_pair", 32'(n_xfer - base), 32'd0);
    exp_q.push_back({16'h4321, 16'h8765});
    send_frame(16'h4321, 16'h8765, 18, 1'b0, 0, DW);
    repeat (4) @(negedge clk);
    check("ferr_next_xfers", 32'(n_xfer - base), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // 64-BCK frame with 1-valued junk after each LSB
    base = n_xfer;
    exp_q.push_back({16'h00F1, 16'hE002});
    send_frame(16'h00F1, 16'hE002, 32, 1'b1, 0, DW);
    repeat (4) @(negedge clk);
    check("junk_xfers", 32'(n_xfer - base), 32'd1);

    // Reset in the middle of a right word, then a clean frame
    base = n_xfer;
    send_frame(16'h9999, 16'h6666, 18, 1'b0, 3, DW);
    repeat (4) @(negedge clk);
    check("mid_rst_xfers", 32'(n_xfer - base), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_ovf",   32'(ovf),   32'd0);
    check("mid_rst_ferr",  32'(ferr),  32'd0);
    check("mid_rst_left",  32'(left),  32'd0);
    exp_q.push_back({16'h2468, 16'h1357});
    send_frame(16'h2468, 16'h1357, 18, 1'b0, 0, DW);
    repeat (4) @(negedge clk);
    check("post_rst_xfers", 32'(n_xfer - base), 32'd1);
    check("post_rst_ferr",  32'(ferr), 32'd0);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
